sort_index_engine: RTL and testbench
====================================

SORT_INDEX_ENGINE -- requirements
Module: sort_index_engine

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, bits per word.
REQ-002 SHALL have parameter NUM_WORDS, default 32, words per array, legal range 1..1024.
REQ-003 SHALL have parameter SIGNED, default 0; 1 compares words as two's complement, 0 as unsigned.
REQ-004 SHALL derive IDX_WIDTH = max(1, clog2(NUM_WORDS)); all internal counters SHALL be IDX_WIDTH bits, with no fixed-width cap.
REQ-005 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-006 SHALL have port rst, input, 1, asynchronous active-low reset.
REQ-007 SHALL have port start, input, 1, request to load array_in and sort.
REQ-008 SHALL have port descend, input, 1, sort order; 0 ascending, 1 descending; sampled with start.
REQ-009 SHALL have port array_in, input, DATA_WIDTH*NUM_WORDS, flat words; word i at bits [i*DATA_WIDTH +: DATA_WIDTH].
REQ-010 SHALL have port array_out, output, DATA_WIDTH*NUM_WORDS, sorted words, same packing as array_in.
REQ-011 SHALL have port idx_out, output, IDX_WIDTH*NUM_WORDS, original index of each output word, same packing.
REQ-012 SHALL have port busy, output, 1, high while sorting.
REQ-013 SHALL have port done, output, 1, high while results are valid.

Function
REQ-014 SHALL implement states IDLE, SCAN, SWAP, DONE; busy=1 exactly in SCAN/SWAP; done=1 exactly in DONE.
REQ-015 SHALL, on a rising edge with start=1 in IDLE or DONE, latch array_in into internal buffer buf, set idx[i]=i, latch descend, set tail=NUM_WORDS-1, p=1, best=0, and enter SCAN (DONE if NUM_WORDS=1).
REQ-016 SHALL ignore start while in SCAN or SWAP; array_in and descend changes after acceptance SHALL NOT affect the result.
REQ-017 SHALL, per SCAN cycle, compare buf[p] with buf[best]: ascending sets best<=p only if buf[p] > buf[best]; descending only if buf[p] < buf[best]; ties keep best.
REQ-018 SHALL, in SCAN, increment p; when p==tail, the compare SHALL still occur and the next state SHALL be SWAP.
REQ-019 SHALL, in SWAP, exchange buf[best]/buf[tail] and idx[best]/idx[tail] in one cycle (no-op if best==tail); then if tail==1 enter DONE, else tail<=tail-1, p<=1, best<=0, enter SCAN.
REQ-020 SHALL assert done on the L-th rising edge after the accepting edge, L = NUM_WORDS*(NUM_WORDS-1)/2 + NUM_WORDS-1, with L=1 when NUM_WORDS=1.
REQ-021 SHALL drive array_out and idx_out continuously from buf and idx; values are defined only while done=1.
REQ-022 SHALL hold done, array_out and idx_out stable in DONE until start is accepted or reset asserts; done SHALL drop on the accepting edge.

Reset
REQ-023 SHALL, while rst=0, force state IDLE, busy=0, done=0, buf all zero, idx all zero, and p, best and tail to zero, regardless of clk.
REQ-024 SHALL abandon any sort in progress on reset; the first start after release SHALL take the full latency L.

Verification (DATA_WIDTH=8, NUM_WORDS=4, word0 listed first; L=9)
REQ-025 SHALL cover: SIGNED=0, descend=0, array_in 5,3,9,1 -> array_out 1,3,5,9; idx_out 3,1,0,2; done on edge 9; busy high edges 1-9.
REQ-026 SHALL cover: same input with descend=1 -> array_out 9,5,3,1; idx_out 2,0,1,3.
REQ-027 SHALL cover: ties, input 7,7,7,7 ascending -> array_out 7,7,7,7; idx_out 1,2,3,0.
REQ-028 SHALL cover: SIGNED=1 ascending, input FF,02,80,00 -> array_out 80,FF,00,02; idx_out 2,0,3,1.
REQ-029 SHALL cover: rst=0 pulse between clock edges at edge 4 of a sort -> busy, done, array_out and idx_out immediately 0; restart yields correct result at edge 9.
REQ-030 SHALL cover: start held high and array_in changed during busy -> result unaffected; start in DONE -> done falls on that edge and the new sort completes L edges later.

Source files
------------

// File: rtl/sort_index_engine.sv
`timescale 1ns/1ps
// sort_index_engine: in-place selection sort of a word array that also tracks each word's original index.
// Each pass scans 0..tail for the extreme word and swaps it into tail, shrinking tail by one.
module sort_index_engine #(
   parameter int DATA_WIDTH = 32,
   parameter int NUM_WORDS = 32,
   parameter bit SIGNED = 0,
   localparam int IDX_WIDTH = NUM_WORDS > 1 ? $clog2(NUM_WORDS) : 1
) (
   input  logic                            clk,
   input  logic                            rst,
   input  logic                            start,
   input  logic                            descend,
   input  logic [DATA_WIDTH*NUM_WORDS-1:0] array_in,
   output logic [DATA_WIDTH*NUM_WORDS-1:0] array_out,
   output logic [IDX_WIDTH*NUM_WORDS-1:0]  idx_out,
   output logic                            busy,
   output logic                            done
);
   typedef enum logic [1:0] {IDLE, SCAN, SWAP, DONE} state_t;
   state_t state, next;
   logic [DATA_WIDTH-1:0] words [NUM_WORDS];
   logic [IDX_WIDTH-1:0]  idx [NUM_WORDS];
   logic [IDX_WIDTH-1:0]  p, best, tail;
   logic                  desc;
   logic                  accept, take;
   logic signed [DATA_WIDTH:0] val_p, val_best;
   assign accept = start && (state == IDLE || state == DONE);
   assign busy = state == SCAN || state == SWAP;
   assign done = state == DONE;
   // One extra sign bit lets a single signed compare serve both number formats.
   always_comb begin
      val_p = {SIGNED && words[p][DATA_WIDTH-1], words[p]};
      val_best = {SIGNED && words[best][DATA_WIDTH-1], words[best]};
      take = desc ? val_p < val_best : val_p > val_best;
   end
   always_comb begin
      next = state;
      case (state)
         IDLE, DONE: next = accept ? (NUM_WORDS == 1 ? DONE : SCAN) : state;
         SCAN: next = p == tail ? SWAP : SCAN;
         SWAP: next = tail == IDX_WIDTH'(1) ? DONE : SCAN;
         default: next = IDLE;
      endcase
   end
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) state <= IDLE;
      else state <= next;
   end
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int i = 0; i < NUM_WORDS; i++) begin
            words[i] <= '0;
            idx[i] <= '0;
         end
         p <= '0;
         best <= '0;
         tail <= '0;
         desc <= 1'b0;
      end else if (accept) begin
         for (int i = 0; i < NUM_WORDS; i++) begin
            words[i] <= array_in[i*DATA_WIDTH +: DATA_WIDTH];
            idx[i] <= IDX_WIDTH'(i);
         end
         desc <= descend;
         tail <= IDX_WIDTH'(NUM_WORDS - 1);
         p <= IDX_WIDTH'(1);
         best <= '0;
      end else if (state == SCAN) begin
         p <= p + IDX_WIDTH'(1);
         if (take) best <= p;
      end else if (state == SWAP) begin
         words[best] <= words[tail];
         words[tail] <= words[best];
         idx[best] <= idx[tail];
         idx[tail] <= idx[best];
         if (tail != IDX_WIDTH'(1)) begin
            tail <= tail - IDX_WIDTH'(1);
            p <= IDX_WIDTH'(1);
            best <= '0;
         end
      end
   end
   for (genvar g = 0; g < NUM_WORDS; g++) begin : g_out
      assign array_out[g*DATA_WIDTH +: DATA_WIDTH] = words[g];
      assign idx_out[g*IDX_WIDTH +: IDX_WIDTH] = idx[g];
   end
endmodule

// File: tb/tb_sort_index_engine.sv
`timescale 1ns/1ps
// tb_sort_index_engine: directed checks of an unsigned and a signed engine driven by the same stimulus.
module tb_sort_index_engine;
   localparam int DW = 8, NW = 4, IW = 2, L = 9;
   typedef struct packed {
      logic [DW*NW-1:0] a_u;
      logic [IW*NW-1:0] i_u;
      logic [DW*NW-1:0] a_s;
      logic [IW*NW-1:0] i_s;
   } exp_t;
   logic clk = 0, rst = 0, start = 0, descend = 0;
   logic [DW*NW-1:0] array_in = '0, aout_u, aout_s;
   logic [IW*NW-1:0] iout_u, iout_s;
   logic busy_u, done_u, busy_s, done_s;
   int total = 0, bad = 0;
   exp_t sb[$];
   localparam logic [31:0] IN1 = {8'd1, 8'd9, 8'd3, 8'd5};
   localparam logic [31:0] ASC1 = {8'd9, 8'd5, 8'd3, 8'd1};
   localparam logic [7:0] ASC1_I = {2'd2, 2'd0, 2'd1, 2'd3};
   localparam logic [31:0] DSC1 = {8'd1, 8'd3, 8'd5, 8'd9};
   localparam logic [7:0] DSC1_I = {2'd3, 2'd1, 2'd0, 2'd2};
   localparam logic [31:0] TIE = {4{8'd7}};
   localparam logic [7:0] TIE_I = {2'd0, 2'd3, 2'd2, 2'd1};
   localparam logic [31:0] IN4 = {8'h00, 8'h80, 8'h02, 8'hFF};
   localparam logic [31:0] U4 = {8'hFF, 8'h80, 8'h02, 8'h00};
   localparam logic [7:0] U4_I = {2'd0, 2'd2, 2'd1, 2'd3};
   localparam logic [31:0] S4 = {8'h02, 8'h00, 8'hFF, 8'h80};
   localparam logic [7:0] S4_I = {2'd1, 2'd3, 2'd0, 2'd2};
   always #5 clk = ~clk;
   sort_index_engine #(.DATA_WIDTH(DW), .NUM_WORDS(NW), .SIGNED(0)) dut_u (
      .clk(clk), .rst(rst), .start(start), .descend(descend), .array_in(array_in),
      .array_out(aout_u), .idx_out(iout_u), .busy(busy_u), .done(done_u));
   sort_index_engine #(.DATA_WIDTH(DW), .NUM_WORDS(NW), .SIGNED(1)) dut_s (
      .clk(clk), .rst(rst), .start(start), .descend(descend), .array_in(array_in),
      .array_out(aout_s), .idx_out(iout_s), .busy(busy_s), .done(done_s));
   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask
   task automatic accept(input logic [31:0] a, input logic d, input bit hold);
      @(negedge clk);
      array_in = a;
      descend = d;
      start = 1;
      @(posedge clk);
      #1;
      chk("accept_done", {62'd0, done_u, done_s}, 64'd0);
      chk("accept_busy", {62'd0, busy_u, busy_s}, 64'd3);
      if (hold) begin
         array_in = ~a;
         descend = ~d;
      end else start = 0;
   endtask
   task automatic finish_sort(input string tag);
      int n = 0;
      exp_t e;
      while (n < L + 5) begin
         @(posedge clk);
         #1;
         n++;
         if (done_u) break;
         chk({tag, "_busy"}, {62'd0, busy_u, busy_s}, 64'd3);
      end
      start = 0;
      chk({tag, "_latency"}, 64'(n), 64'(L));
      chk({tag, "_done"}, {62'd0, done_u, done_s}, 64'd3);
      e = sb.pop_front();
      chk({tag, "_arr_u"}, 64'(aout_u), 64'(e.a_u));
      chk({tag, "_idx_u"}, 64'(iout_u), 64'(e.i_u));
      chk({tag, "_arr_s"}, 64'(aout_s), 64'(e.a_s));
      chk({tag, "_idx_s"}, 64'(iout_s), 64'(e.i_s));
   endtask
   initial begin
      #1;
      chk("reset_flags", {60'd0, busy_u, done_u, busy_s, done_s}, 64'd0);
      chk("reset_data", {aout_u, iout_u, 24'd0}, 64'd0);
      repeat (2) @(negedge clk);
      rst = 1;
      sb.push_back('{ASC1, ASC1_I, ASC1, ASC1_I});
      accept(IN1, 0, 0);
      finish_sort("asc");
      repeat (2) @(posedge clk);
      #1;
      chk("done_hold", {32'd0, aout_u}, {32'd0, ASC1});
      sb.push_back('{DSC1, DSC1_I, DSC1, DSC1_I});
      accept(IN1, 1, 0);
      finish_sort("desc");
      sb.push_back('{TIE, TIE_I, TIE, TIE_I});
      accept(TIE, 0, 0);
      finish_sort("ties");
      sb.push_back('{U4, U4_I, S4, S4_I});
      accept(IN4, 0, 0);
      finish_sort("signed");
      accept(IN1, 0, 0);
      repeat (3) @(posedge clk);
      #2;
      rst = 0;
      #1;
      chk("abort_flags", {60'd0, busy_u, done_u, busy_s, done_s}, 64'd0);
      chk("abort_data_u", {24'd0, aout_u, iout_u}, 64'd0);
      chk("abort_data_s", {24'd0, aout_s, iout_s}, 64'd0);
      #1;
      rst = 1;
      sb.push_back('{U4, U4_I, S4, S4_I});
      accept(IN4, 0, 0);
      finish_sort("after_rst");
      sb.push_back('{ASC1, ASC1_I, ASC1, ASC1_I});
      accept(IN1, 0, 1);
      finish_sort("hold");
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
